// File: rtl/fact_pkg.sv
// Shared types and constants for the buffered factorial engine.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  // Largest n whose factorial still fits in 32 bits.
  localparam int FACT_MAX_NO_OVF_32 = 12;

endpackage

// File: rtl/fact_seq_engine_if.sv
// Request/result handshake bundle between a producer/consumer and fact_seq_engine.
interface fact_seq_engine_if #(
  parameter int DATA_W = 32,
  parameter int N_W    = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [N_W-1:0]    in_n;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_fact;
  logic              out_ovf;
  logic [N_W-1:0]    out_n;
  logic              busy;

  modport slave (
    input  in_valid, in_n, out_ready,
    output in_ready, out_valid, out_fact, out_ovf, out_n, busy
  );

  modport master (
    output in_valid, in_n, out_ready,
    input  in_ready, out_valid, out_fact, out_ovf, out_n, busy
  );

endinterface

// File: rtl/fact_req_fifo.sv
// Request queue for the factorial engine; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module fact_req_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the reset pointers make every entry unreadable.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fact_seq_engine.sv
// Buffered iterative factorial engine: queued requests, one multiply per clock,
// result held on a valid/ready output with a sticky overflow flag.
module fact_seq_engine
  import fact_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int N_W        = 5,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  fact_seq_engine_if.slave  bus
);

  localparam logic [N_W-1:0]    CNT_ONE = 1;
  localparam logic [DATA_W-1:0] ACC_ONE = 1;

  state_t              state;
  state_t              state_nxt;
  logic [N_W-1:0]      head_n;
  logic                q_full;
  logic                q_empty;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   acc;
  logic [N_W-1:0]      cnt;
  logic                ovf;
  logic [N_W-1:0]      nreg;
  logic [2*DATA_W-1:0] prod;
  logic                is_done;

  assign bus.in_ready = !q_full && rst_n;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && !q_empty;

  fact_req_fifo #(
    .W     (N_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.in_n),
    .pop   (pop),
    .dout  (head_n),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!q_empty)      state_nxt = MUL;
      MUL:     if (cnt <= CNT_ONE) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Full-width product so the overflow check sees every carried-out bit.
  assign prod = {{DATA_W{1'b0}}, acc} * {{(2*DATA_W-N_W){1'b0}}, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      nreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!q_empty) begin
            acc  <= ACC_ONE;
            cnt  <= head_n;
            ovf  <= 1'b0;
            nreg <= head_n;
          end
        end
        MUL: begin
          if (cnt > CNT_ONE) begin
            acc <= prod[DATA_W-1:0];
            ovf <= ovf | (|prod[2*DATA_W-1:DATA_W]);
            cnt <= cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by DONE so a partial accumulator never leaks out.
  assign is_done       = (state == DONE);
  assign bus.out_valid = is_done;
  assign bus.out_fact  = is_done ? acc  : '0;
  assign bus.out_ovf   = is_done ? ovf  : 1'b0;
  assign bus.out_n     = is_done ? nreg : '0;
  assign bus.busy      = (state != IDLE) || !q_empty;

endmodule

// File: tb/tb_fact_seq_engine.sv
// Scoreboard bench for fact_seq_engine: expected results are queued as
// requests are accepted and compared when results are handed over.
module tb_fact_seq_engine;

  typedef struct {
    logic [4:0]  n;
    logic [31:0] f;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   n_rx  = 0;
  exp_t sb[$];

  logic        held;
  logic [31:0] prev_f;
  logic [4:0]  prev_n;
  logic        prev_o;
  bit          rnd_done;

  always #5 clk = ~clk;

  fact_seq_engine_if #(.DATA_W(32), .N_W(5)) ifc ();

  fact_seq_engine #(
    .DATA_W     (32),
    .N_W        (5),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // n! mod 2^32 by repeated modular multiply; true n! exceeds 32 bits from n=13 on.
  function automatic exp_t model(input logic [4:0] n);
    exp_t        e;
    logic [31:0] p = 32'd1;
    for (int k = 2; k <= int'(n); k++) p = p * 32'(k);
    e.n = n;
    e.f = p;
    e.o = (n >= 5'd13);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_exp(input logic [4:0] n, input logic [31:0] f, input logic o);
    int   waited = 0;
    exp_t e;
    ifc.in_valid = 1'b1;
    ifc.in_n     = n;
    while (!ifc.in_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ifc.in_ready) begin
      check("send_timeout", 64'd1, 64'd0);
    end else begin
      e.n = n; e.f = f; e.o = o;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] n);
    exp_t e = model(n);
    send_exp(n, e.f, e.o);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while ((sb.size() != 0 || ifc.busy) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Result monitor: compares handed-over results and checks hold stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(ifc.out_valid), 64'd1);
        check("hold_fact",  64'(ifc.out_fact),  64'(prev_f));
        check("hold_n",     64'(ifc.out_n),     64'(prev_n));
        check("hold_ovf",   64'(ifc.out_ovf),   64'(prev_o));
      end
      if (ifc.out_valid && ifc.out_ready) begin
        held = 1'b0;
        n_rx++;
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("res_n",    64'(ifc.out_n),    64'(e.n));
          check("res_fact", 64'(ifc.out_fact), 64'(e.f));
          check("res_ovf",  64'(ifc.out_ovf),  64'(e.o));
        end
      end else if (ifc.out_valid) begin
        held   = 1'b1;
        prev_f = ifc.out_fact;
        prev_n = ifc.out_n;
        prev_o = ifc.out_ovf;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic [4:0] rn;

    ifc.in_valid  = 1'b0;
    ifc.in_n      = '0;
    ifc.out_ready = 1'b1;
    held          = 1'b0;
    rst_n         = 1'b0;
    #1;
    check("rst_valid",    64'(ifc.out_valid), 64'd0);
    check("rst_fact",     64'(ifc.out_fact),  64'd0);
    check("rst_ovf",      64'(ifc.out_ovf),   64'd0);
    check("rst_n_out",    64'(ifc.out_n),     64'd0);
    check("rst_busy",     64'(ifc.busy),      64'd0);
    check("rst_in_ready", 64'(ifc.in_ready),  64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(ifc.in_ready), 64'd1);

    // 1: latency and single-cycle result pulse for n=5
    send_exp(5'd5, 32'd120, 1'b0);
    cyc = 0;
    while (!ifc.out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t1_latency", 64'(cyc), 64'd6);
    @(posedge clk); #1;
    check("t1_pulse", 64'(ifc.out_valid), 64'd0);
    wait_drain("t1_drain", 100);

    // 2: 0! and 1! back to back
    send_exp(5'd0, 32'd1, 1'b0);
    send_exp(5'd1, 32'd1, 1'b0);
    wait_drain("t2_drain", 100);

    // 3: overflow boundary
    send_exp(5'd12, 32'd479001600, 1'b0);
    send_exp(5'd13, 32'd1932053504, 1'b1);
    send(5'd31);
    wait_drain("t3_drain", 300);

    // 4: back-pressure fills the queue, then releases in order
    ifc.out_ready = 1'b0;
    n_rx = 0;
    send(5'd3); send(5'd4); send(5'd2); send(5'd7); send(5'd0);
    check("t4_full", 64'(ifc.in_ready), 64'd0);
    check("t4_busy", 64'(ifc.busy),     64'd1);
    ifc.in_valid = 1'b1;
    ifc.in_n     = 5'd6;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t4_refuse", 64'(ifc.in_ready), 64'd0);
    end
    ifc.out_ready = 1'b1;
    send(5'd6);
    wait_drain("t4_drain", 300);
    check("t4_count", 64'(n_rx), 64'd6);

    // 5: reset during a long multiply with two requests queued
    send(5'd10); send(5'd2); send(5'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_valid",    64'(ifc.out_valid), 64'd0);
    check("t5_fact",     64'(ifc.out_fact),  64'd0);
    check("t5_ovf",      64'(ifc.out_ovf),   64'd0);
    check("t5_n",        64'(ifc.out_n),     64'd0);
    check("t5_busy",     64'(ifc.busy),      64'd0);
    check("t5_in_ready", 64'(ifc.in_ready),  64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_exp(5'd4, 32'd24, 1'b0);
    wait_drain("t5_drain", 100);

    // 6: random traffic with random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int c = 0; c < 2000; c++) begin
          @(posedge clk); #1;
          rn = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 14)) : 5'($urandom_range(0, 31));
          ifc.in_valid = ($urandom_range(0, 3) == 0);
          ifc.in_n     = rn;
          if (ifc.in_valid && ifc.in_ready) sb.push_back(model(rn));
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ifc.out_ready = ($urandom_range(0, 2) != 0);
        end
        ifc.out_ready = 1'b1;
      end
    join
    wait_drain("t6_drain", 5000);
    check("t6_idle", 64'(ifc.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
